patmos_wb_ctrl: RTL and testbench
=================================

Name: patmos_wb_ctrl

Overview:
Wishbone B4 classic slave register bank in the user project area. It lets the management SoC firmware control the Patmos core: boot address, stall and reset. It also gives write access to the two boot-memory banks (odd and even words). Every register is read/write, so firmware can read back the value it wrote.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window.
- BMEM_ADDR_W, 16, width of the boot-memory address registers.

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_sel_i  in  4  byte lane selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- boot_addr_o  out  32  Patmos boot address
- core_stall_o  out  1  Patmos stall
- core_reset_o  out  1  Patmos reset, active-high
- bmem_odd_data_o  out  32  odd-bank write data
- bmem_odd_addr_o  out  BMEM_ADDR_W  odd-bank word address
- bmem_odd_en_o  out  1  odd-bank write enable
- bmem_even_data_o  out  32  even-bank write data
- bmem_even_addr_o  out  BMEM_ADDR_W  even-bank word address
- bmem_even_en_o  out  1  even-bank write enable

Behaviour:
- Select: cyc & stb & (wbs_adr_i[31:8] == BASE_ADDR[31:8]). Register offset is wbs_adr_i[7:0]. Bits [1:0] are ignored (word aligned).
- Register map (offset, name, width, reset value):
  - 0x00 BOOT_ADDR, 32, 0
  - 0x04 STALL, 1, 0
  - 0x08 RESET, 1, 1 (core is held in reset after wb_rst_i)
  - 0x0C ODD_DATA, 32, 0
  - 0x10 ODD_ADDR, BMEM_ADDR_W, 0
  - 0x14 ODD_EN, 1, 0
  - 0x18 EVEN_DATA, 32, 0
  - 0x1C EVEN_ADDR, BMEM_ADDR_W, 0
  - 0x20 EVEN_EN, 1, 0
- Each output is driven directly by its register. ODD_EN and EVEN_EN are levels, not pulses, and stay set until firmware writes 0.
- Handshake:
  - On the first cycle that select is true and wbs_ack_o is 0, register wbs_ack_o = 1 for exactly one cycle.
  - The next cycle ack returns to 0, even if stb is still high. Every access therefore takes 2 cycles minimum. Back-to-back accesses are allowed after ack drops.
- Writes: committed on the same clock edge that raises ack. Byte lanes are honoured via wbs_sel_i. For narrow registers, only bits that exist and are covered by a selected lane are updated.
- Reads: wbs_dat_o is registered with the same edge as ack and holds the register value zero-extended to 32 bits. wbs_dat_o is 0 whenever ack is 0.
- Unmapped offsets (0x24–0xFC): writes are ignored, reads return 0, and ack is still generated (no bus hang).
- Address outside the window: no ack, no state change.
- Reset: wb_rst_i is synchronous. All registers take their reset values, wbs_ack_o = 0, wbs_dat_o = 0. Reset asserted mid-transaction aborts it: no write commits and no ack that cycle. The master must retry.
- Simultaneous stb and reset: reset wins.

Test Plan:
- Reset, then read all 9 offsets -> 0 everywhere except RESET = 1. core_reset_o = 1, all other outputs 0.
- Write 0x123 to 0x00 and read it back -> 0x123, boot_addr_o = 0x123. Write 1 to 0x04 -> read 1, core_stall_o = 1. Write 0 to 0x08 -> read 0, core_reset_o = 0.
- Write 0x501 to 0x0C, 0x44 to 0x10, 1 to 0x14 -> each reads back the same value. Odd outputs are 0x501 / 0x44 / 1. Even outputs remain 0.
- Write 0x78 to 0x18, 0x12 to 0x1C, 1 to 0x20 -> each reads back the same value. Even outputs are 0x78 / 0x12 / 1.
- Write 0xAABBCCDD to 0x00 with sel = 4'b0010 when BOOT_ADDR = 0x123 -> BOOT_ADDR = 0x0000CC23. Write to 0x40 -> acked, reads 0. Access at 0x2000_0000 -> no ack within 4 cycles.
- Hold stb high for 5 cycles -> exactly one ack pulse. Assert wb_rst_i during a pending write -> register keeps its reset value.

Source files
------------

// File: rtl/patmos_wb_ctrl.sv
// Wishbone B4 classic slave register bank for the Patmos core: boot address,
// stall/reset control and write ports for the odd/even boot-memory banks.
module patmos_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          BMEM_ADDR_W = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [31:0]            boot_addr_o,
  output logic                   core_stall_o,
  output logic                   core_reset_o,
  output logic [31:0]            bmem_odd_data_o,
  output logic [BMEM_ADDR_W-1:0] bmem_odd_addr_o,
  output logic                   bmem_odd_en_o,
  output logic [31:0]            bmem_even_data_o,
  output logic [BMEM_ADDR_W-1:0] bmem_even_addr_o,
  output logic                   bmem_even_en_o
);

  localparam logic [5:0] W_BOOT_ADDR = 6'h00;
  localparam logic [5:0] W_STALL     = 6'h01;
  localparam logic [5:0] W_RESET     = 6'h02;
  localparam logic [5:0] W_ODD_DATA  = 6'h03;
  localparam logic [5:0] W_ODD_ADDR  = 6'h04;
  localparam logic [5:0] W_ODD_EN    = 6'h05;
  localparam logic [5:0] W_EVEN_DATA = 6'h06;
  localparam logic [5:0] W_EVEN_ADDR = 6'h07;
  localparam logic [5:0] W_EVEN_EN   = 6'h08;

  logic                   sel_hit;
  logic                   access;
  logic                   served;
  logic [5:0]             word;
  logic                   adr_unused;
  logic [31:0]            read_val;

  logic [31:0]            boot_addr;
  logic                   stall;
  logic                   core_reset;
  logic [31:0]            odd_data;
  logic [BMEM_ADDR_W-1:0] odd_addr;
  logic                   odd_en;
  logic [31:0]            even_data;
  logic [BMEM_ADDR_W-1:0] even_addr;
  logic                   even_en;

  logic [31:0]            m_boot_addr;
  logic [31:0]            m_stall;
  logic [31:0]            m_reset;
  logic [31:0]            m_odd_data;
  logic [31:0]            m_odd_addr;
  logic [31:0]            m_odd_en;
  logic [31:0]            m_even_data;
  logic [31:0]            m_even_addr;
  logic [31:0]            m_even_en;

  // Byte-lane merge: selected lanes take write data, others keep the current value.
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wr,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? wr[b*8 +: 8] : cur[b*8 +: 8];
    end
    return res;
  endfunction

  assign sel_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // served stops a strobe held high across several cycles from being acked twice.
  assign access     = sel_hit & ~wbs_ack_o & ~served;
  assign word       = wbs_adr_i[7:2];
  assign adr_unused = ^wbs_adr_i[1:0];

  assign m_boot_addr = lane_merge(boot_addr,       wbs_dat_i, wbs_sel_i);
  assign m_stall     = lane_merge(32'(stall),      wbs_dat_i, wbs_sel_i);
  assign m_reset     = lane_merge(32'(core_reset), wbs_dat_i, wbs_sel_i);
  assign m_odd_data  = lane_merge(odd_data,        wbs_dat_i, wbs_sel_i);
  assign m_odd_addr  = lane_merge(32'(odd_addr),   wbs_dat_i, wbs_sel_i);
  assign m_odd_en    = lane_merge(32'(odd_en),     wbs_dat_i, wbs_sel_i);
  assign m_even_data = lane_merge(even_data,       wbs_dat_i, wbs_sel_i);
  assign m_even_addr = lane_merge(32'(even_addr),  wbs_dat_i, wbs_sel_i);
  assign m_even_en   = lane_merge(32'(even_en),    wbs_dat_i, wbs_sel_i);

  always_comb begin
    read_val = 32'h0;
    case (word)
      W_BOOT_ADDR: read_val = boot_addr;
      W_STALL:     read_val = 32'(stall);
      W_RESET:     read_val = 32'(core_reset);
      W_ODD_DATA:  read_val = odd_data;
      W_ODD_ADDR:  read_val = 32'(odd_addr);
      W_ODD_EN:    read_val = 32'(odd_en);
      W_EVEN_DATA: read_val = even_data;
      W_EVEN_ADDR: read_val = 32'(even_addr);
      W_EVEN_EN:   read_val = 32'(even_en);
      default:     read_val = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      served     <= 1'b0;
      boot_addr  <= 32'h0;
      stall      <= 1'b0;
      core_reset <= 1'b1;
      odd_data   <= 32'h0;
      odd_addr   <= '0;
      odd_en     <= 1'b0;
      even_data  <= 32'h0;
      even_addr  <= '0;
      even_en    <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      served    <= sel_hit & (served | access);
      wbs_dat_o <= 32'h0;
      if (access) begin
        if (wbs_we_i) begin
          case (word)
            W_BOOT_ADDR: boot_addr  <= m_boot_addr;
            W_STALL:     stall      <= m_stall[0];
            W_RESET:     core_reset <= m_reset[0];
            W_ODD_DATA:  odd_data   <= m_odd_data;
            W_ODD_ADDR:  odd_addr   <= m_odd_addr[BMEM_ADDR_W-1:0];
            W_ODD_EN:    odd_en     <= m_odd_en[0];
            W_EVEN_DATA: even_data  <= m_even_data;
            W_EVEN_ADDR: even_addr  <= m_even_addr[BMEM_ADDR_W-1:0];
            W_EVEN_EN:   even_en    <= m_even_en[0];
            default: ;
          endcase
        end else begin
          wbs_dat_o <= read_val;
        end
      end
    end
  end

  assign boot_addr_o      = boot_addr;
  assign core_stall_o     = stall;
  assign core_reset_o     = core_reset;
  assign bmem_odd_data_o  = odd_data;
  assign bmem_odd_addr_o  = odd_addr;
  assign bmem_odd_en_o    = odd_en;
  assign bmem_even_data_o = even_data;
  assign bmem_even_addr_o = even_addr;
  assign bmem_even_en_o   = even_en;

endmodule

// File: tb/tb_patmos_wb_ctrl.sv
// Directed self-checking bench for patmos_wb_ctrl.
module tb_patmos_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] boot_addr;
  logic        core_stall, core_reset;
  logic [31:0] odd_data, even_data;
  logic [15:0] odd_addr, even_addr;
  logic        odd_en, even_en;

  int checks = 0;
  int passed = 0;

  patmos_wb_ctrl #(.BASE_ADDR(32'h3000_0000), .BMEM_ADDR_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .boot_addr_o(boot_addr), .core_stall_o(core_stall), .core_reset_o(core_reset),
    .bmem_odd_data_o(odd_data), .bmem_odd_addr_o(odd_addr), .bmem_odd_en_o(odd_en),
    .bmem_even_data_o(even_data), .bmem_even_addr_o(even_addr), .bmem_even_en_o(even_en)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got, output logic [31:0] q);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    got = 1'b0; q = 32'hxxxx_xxxx;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1; q = rdat;
        break;
      end
    end
    @(negedge clk);
    bus_idle();
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input string name);
    logic got; logic [31:0] q;
    wb_access(1'b1, a, d, s, got, q);
    checks++;
    if (got !== 1'b1) $display("FAIL %s write ack: got %b want 1", name, got);
    else passed++;
  endtask

  task automatic rd_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic got; logic [31:0] q;
    wb_access(1'b0, a, 32'h0, 4'hF, got, q);
    checks++;
    if (got !== 1'b1 || q !== exp)
      $display("FAIL %s read: ack %b data %h want %h", name, got, q, exp);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || rdat !== 32'h0) $display("FAIL reset bus: ack %b dat %h want 0 0", ack, rdat);
    else passed++;
    checks++;
    if (core_reset !== 1'b1 || core_stall !== 1'b0 || boot_addr !== 32'h0)
      $display("FAIL reset core outs: reset %b stall %b boot %h want 1 0 0", core_reset, core_stall, boot_addr);
    else passed++;
    checks++;
    if ({odd_data, odd_addr, odd_en, even_data, even_addr, even_en} !== 98'h0)
      $display("FAIL reset bmem outs: %h %h %b %h %h %b want all 0",
               odd_data, odd_addr, odd_en, even_data, even_addr, even_en);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      exp = (i == 2) ? 32'h1 : 32'h0;
      rd_expect(32'h3000_0000 + 32'(i * 4), exp, $sformatf("reset_reg%0d", i));
    end
  endtask

  task automatic test_core_ctrl();
    wr(32'h3000_0000, 32'h123, 4'hF, "boot_addr");
    rd_expect(32'h3000_0000, 32'h123, "boot_addr");
    checks++;
    if (boot_addr !== 32'h123) $display("FAIL boot_addr_o: got %h want 00000123", boot_addr);
    else passed++;
    wr(32'h3000_0004, 32'h1, 4'hF, "stall");
    rd_expect(32'h3000_0004, 32'h1, "stall");
    checks++;
    if (core_stall !== 1'b1) $display("FAIL core_stall_o: got %b want 1", core_stall);
    else passed++;
    wr(32'h3000_0008, 32'h0, 4'hF, "reset");
    rd_expect(32'h3000_0008, 32'h0, "reset");
    checks++;
    if (core_reset !== 1'b0) $display("FAIL core_reset_o: got %b want 0", core_reset);
    else passed++;
  endtask

  task automatic test_odd_bank();
    wr(32'h3000_000C, 32'h501, 4'hF, "odd_data");
    wr(32'h3000_0010, 32'h44,  4'hF, "odd_addr");
    wr(32'h3000_0014, 32'h1,   4'hF, "odd_en");
    rd_expect(32'h3000_000C, 32'h501, "odd_data");
    rd_expect(32'h3000_0010, 32'h44,  "odd_addr");
    rd_expect(32'h3000_0014, 32'h1,   "odd_en");
    checks++;
    if (odd_data !== 32'h501 || odd_addr !== 16'h44 || odd_en !== 1'b1)
      $display("FAIL odd outs: %h %h %b want 00000501 0044 1", odd_data, odd_addr, odd_en);
    else passed++;
    checks++;
    if (even_data !== 32'h0 || even_addr !== 16'h0 || even_en !== 1'b0)
      $display("FAIL even untouched: %h %h %b want 0 0 0", even_data, even_addr, even_en);
    else passed++;
  endtask

  task automatic test_even_bank();
    wr(32'h3000_0018, 32'h78, 4'hF, "even_data");
    wr(32'h3000_001C, 32'h12, 4'hF, "even_addr");
    wr(32'h3000_0020, 32'h1,  4'hF, "even_en");
    rd_expect(32'h3000_0018, 32'h78, "even_data");
    rd_expect(32'h3000_001C, 32'h12, "even_addr");
    rd_expect(32'h3000_0020, 32'h1,  "even_en");
    checks++;
    if (even_data !== 32'h78 || even_addr !== 16'h12 || even_en !== 1'b1)
      $display("FAIL even outs: %h %h %b want 00000078 0012 1", even_data, even_addr, even_en);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    wr(32'h3000_0000, 32'hAABB_CCDD, 4'b0010, "boot_lane1");
    rd_expect(32'h3000_0000, 32'h0000_CC23, "boot_lane1");
    // Stall bit lives in lane 0; a write without lane 0 must leave it set.
    wr(32'h3000_0004, 32'h0, 4'b1110, "stall_nolane0");
    rd_expect(32'h3000_0004, 32'h1, "stall_nolane0");
    wr(32'h3000_0010, 32'hFFFF_9900, 4'b1100, "odd_addr_hi_lanes");
    rd_expect(32'h3000_0010, 32'h44, "odd_addr_hi_lanes");
    wr(32'h3000_0010, 32'hFFFF_9900, 4'b0010, "odd_addr_lane1");
    rd_expect(32'h3000_0010, 32'h9944, "odd_addr_lane1");
  endtask

  task automatic test_unmapped_and_window();
    int acks;
    wr(32'h3000_0040, 32'hFFFF_FFFF, 4'hF, "unmapped");
    rd_expect(32'h3000_0040, 32'h0, "unmapped");
    rd_expect(32'h3000_0000, 32'h0000_CC23, "boot_after_unmapped");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h2000_0000; wdat = 32'h5555_5555; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    @(negedge clk);
    bus_idle();
    checks++;
    if (acks !== 0) $display("FAIL outside_window acks: got %0d want 0", acks);
    else passed++;
    checks++;
    if (boot_addr !== 32'h0000_CC23) $display("FAIL outside_window state: boot %h want 0000cc23", boot_addr);
    else passed++;
  endtask

  task automatic test_stb_hold();
    int acks;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    @(negedge clk);
    bus_idle();
    @(posedge clk);
    checks++;
    if (acks !== 1) $display("FAIL stb_hold acks: got %0d want 1", acks);
    else passed++;
  endtask

  task automatic test_back_to_back();
    wr(32'h3000_000C, 32'hCAFE_0001, 4'hF, "b2b_w1");
    wr(32'h3000_0018, 32'hCAFE_0002, 4'hF, "b2b_w2");
    rd_expect(32'h3000_000C, 32'hCAFE_0001, "b2b_r1");
    rd_expect(32'h3000_0018, 32'hCAFE_0002, "b2b_r2");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h0000_DEAD; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) $display("FAIL reset_mid ack: got %b want 0", ack);
    else passed++;
    checks++;
    if (boot_addr !== 32'h0 || core_reset !== 1'b1 || odd_en !== 1'b0)
      $display("FAIL reset_mid state: boot %h reset %b odd_en %b want 0 1 0", boot_addr, core_reset, odd_en);
    else passed++;
    @(negedge clk);
    bus_idle();
    rst = 1'b0;
    rd_expect(32'h3000_0000, 32'h0, "reset_mid_boot");
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    test_reset();
    test_core_ctrl();
    test_odd_bank();
    test_even_bank();
    test_byte_lanes();
    test_unmapped_and_window();
    test_stb_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
